// File: rtl/wb_master_port_if.sv
// Command/response channels plus Wishbone pipelined-mode bus for wb_master_port.
// The master modport is the initiator's view; slave is its environment (requester + bus slave).
interface wb_master_port_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_data
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_data
    );
endinterface

// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone pipelined initiator; rsp_valid 2 edges after cmd handshake with a zero-stall next-cycle-ack slave.
// Stall holds stb/fields; rsp held until rsp_ready, cmd_ready low until then plus one idle cycle; timeout forces an error response.
module wb_master_port #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    wb_master_port_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } req_t;

    state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    req_t        req_q, req_nxt;
    logic        cyc_q, cyc_nxt;
    logic        stb_q, stb_nxt;
    logic        cmd_ready_q, cmd_ready_nxt;
    logic        rsp_valid_q, rsp_valid_nxt;
    logic [31:0] rsp_rdata_q, rsp_rdata_nxt;
    logic        rsp_err_q, rsp_err_nxt;

    logic accept, ack_ok, timeout;

    // An ack only counts once the request has been taken (no stall) or while waiting.
    assign accept  = (state == IDLE) && bus.cmd_valid;
    assign ack_ok  = bus.i_wb_ack && (((state == REQ) && !bus.i_wb_stall) || (state == WAIT));
    assign timeout = ((state == REQ) || (state == WAIT)) && !ack_ok &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            req_q       <= req_nxt;
            cyc_q       <= cyc_nxt;
            stb_q       <= stb_nxt;
            cmd_ready_q <= cmd_ready_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            rsp_err_q   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ: begin
                if (ack_ok || timeout)    state_nxt = RSP;
                else if (!bus.i_wb_stall) state_nxt = WAIT;
            end
            WAIT: if (ack_ok || timeout) state_nxt = RSP;
            RSP:  if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt       = cnt;
        req_nxt       = req_q;
        cyc_nxt       = 1'b0;
        stb_nxt       = 1'b0;
        cmd_ready_nxt = 1'b0;
        rsp_valid_nxt = rsp_valid_q;
        rsp_rdata_nxt = rsp_rdata_q;
        rsp_err_nxt   = rsp_err_q;
        case (state)
            IDLE: begin
                cmd_ready_nxt = !bus.cmd_valid;
                if (accept) begin
                    req_nxt = '{we: bus.cmd_we, addr: bus.cmd_addr,
                                data: bus.cmd_wdata, sel: bus.cmd_sel};
                    cnt_nxt = '0;
                    cyc_nxt = 1'b1;
                    stb_nxt = 1'b1;
                end
            end
            REQ, WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                cyc_nxt = !(ack_ok || timeout);
                stb_nxt = (state == REQ) && bus.i_wb_stall && !timeout;
                if (ack_ok) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = req_q.we ? 32'h0 : bus.i_wb_data;
                end else if (timeout) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = 32'h0;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.o_wb_cyc  = cyc_q;
    assign bus.o_wb_stb  = stb_q;
    assign bus.o_wb_we   = req_q.we;
    assign bus.o_wb_addr = req_q.addr;
    assign bus.o_wb_data = req_q.data;
    assign bus.o_wb_sel  = req_q.sel;
endmodule

// File: doc/wb_master_port.md
Name: wb_master_port

Overview:
- Single-outstanding Wishbone pipelined-mode initiator.
- Turns one command-channel request (read or write) into one Wishbone transaction and returns the result on a response channel.
- Sits between on-chip requesters (audio sample streamer, debug bridge) and the peripheral bus logic that decodes 0x8000_00xx. Drives cyc/stb/we/addr/data/sel; honours stall and ack.
- Bus timeout guarantees forward progress if no slave acknowledges.

Parameters:
- TIMEOUT_CYCLES, 256: cycles after stb first asserts before the transaction is abandoned with error; legal range 2..65535.
- CNT_W, 16: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_sel  in  4  byte enables
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  32  read data; 0 for writes and on error
- rsp_err  out  1  1 = timeout
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  32  address
- o_wb_data  out  32  write data
- o_wb_sel  out  4  byte select
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  slave acknowledge
- i_wb_data  in  32  slave read data

Behaviour:
- One clock, clk. Reset is synchronous, active-low (reset_n sampled low at a rising edge). All outputs are registered.
- Reset values: every output is 0, except cmd_ready = 1. State = IDLE, counter = 0.
- Reset mid-transaction: cyc and stb drop at that edge. Any pending response is discarded. No rsp_valid is produced afterwards for that command.
- States: IDLE, REQ, WAIT, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at an edge: latch we/addr/wdata/sel onto o_wb_*, set cyc = stb = 1, clear counter, cmd_ready = 0, go to REQ.
- REQ:
  - stb and all request fields are held stable.
  - At each edge with i_wb_stall = 0, the request is taken: stb drops.
  - If i_wb_ack is also 1 at that edge, treat it as WAIT's ack (below) and go to RSP. Otherwise go to WAIT.
  - An ack seen while stall = 1 is ignored.
- WAIT:
  - cyc = 1, stb = 0.
  - On i_wb_ack: capture i_wb_data into rsp_rdata (0 if the command was a write), rsp_err = 0, cyc = 0, rsp_valid = 1, go to RSP.
- Timeout:
  - Counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 with no qualifying ack at that edge: cyc = stb = 0, rsp_err = 1, rsp_rdata = 0, rsp_valid = 1, go to RSP.
  - An ack arriving at that same edge wins; no error is reported.
- RSP:
  - rsp_valid and rsp_err/rsp_rdata are held until an edge with rsp_ready = 1. Then rsp_valid = 0, cmd_ready = 1, go to IDLE.
  - No new command is accepted in the same edge; minimum 1 idle cycle between transactions.
- Stray ack in IDLE or RSP is ignored. cyc never asserts outside REQ/WAIT.
- Latency with zero-stall slave that acks one cycle after the strobe:
  - Command handshake at edge 0.
  - stb high between edges 0 and 1; ack high between edges 1 and 2.
  - rsp_valid high from edge 2.
- o_wb_data/o_wb_sel/o_wb_we are only meaningful while stb = 1. They retain their values otherwise.

Test Plan:
- Write LED: cmd_we=1, addr 0x8000_0004, wdata 0x0000_00A5, sel 0001, zero-stall ack-next-cycle slave -> exactly one stb cycle with those values; rsp_valid at edge 2; rsp_err=0; rsp_rdata=0.
- Read DIP: cmd_we=0, addr 0x8000_0000, slave returns 0x0000_003C with ack -> rsp_rdata=0x0000_003C, rsp_err=0; cyc low the cycle after ack.
- Stall: i_wb_stall high 3 cycles after stb asserts -> stb and fields held 4 cycles, then drop; ack 1 cycle later -> single response, no duplicate stb.
- Timeout: TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 cycles in REQ/WAIT; rsp_valid=1, rsp_err=1, rsp_rdata=0; a late ack afterwards is ignored.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid; second cmd_valid pending -> response stable; cmd_ready=0 throughout; second command accepted only after the rsp_ready handshake plus one cycle.
- Reset mid-operation: reset_n low for 1 edge while in WAIT -> all outputs 0, cmd_ready=1 after that edge; a subsequent ack produces no response.
